// File: rtl/datapath.sv
// Four-lane, 4-bit SIMD accumulator datapath.
// Each lane keeps a 4-bit accumulator and a carry/borrow flag. A 3-bit opcode
// combines each accumulator with its lane operand every clock; only lanes
// selected by vec are updated. Lanes are fully independent: no carry ripples
// between them and the stored carry is never read back as an operand.
module datapath (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] op,
  input  logic       form,
  input  logic [1:0] vec,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  output logic [3:0] QA,
  output logic [3:0] QB,
  output logic [3:0] QC,
  output logic [3:0] QD,
  output logic [3:0] carry,
  output logic       zero
);

  localparam int unsigned LANES = 4;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

  op_e              w_op;
  logic [3:0]       w_in [LANES];
  logic [3:0]       w_q  [LANES];
  logic [LANES-1:0] w_lane_en;
  logic [LANES-1:0] w_carry;

  assign w_op = op_e'(op);

  // Per-lane raw operands, lane i = A/B/C/D.
  assign w_in[0] = A;
  assign w_in[1] = B;
  assign w_in[2] = C;
  assign w_in[3] = D;

  // Thermometer decode of vec: lanes 0..vec are active.
  always_comb begin
    w_lane_en = 4'b0001;
    case (vec)
      2'd0: w_lane_en = 4'b0001;
      2'd1: w_lane_en = 4'b0011;
      2'd2: w_lane_en = 4'b0111;
      2'd3: w_lane_en = 4'b1111;
      default: w_lane_en = 4'b0001;
    endcase
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [3:0] r_q;
    logic       r_k;
    logic [3:0] w_n;
    logic [4:0] w_sum;
    logic [4:0] w_diff;
    logic [3:0] w_r;
    logic       w_k;
    logic       w_upd;

    // Broadcast mode feeds lane 0's input to every lane.
    assign w_n    = form ? A : w_in[gi];
    // 5-bit widening exposes carry-out (sum) and borrow (difference) in bit 4.
    assign w_sum  = {1'b0, r_q} + {1'b0, w_n};
    assign w_diff = {1'b0, r_q} - {1'b0, w_n};

    // Next-value selection for this lane; NOP suppresses the update entirely.
    always_comb begin
      w_r   = r_q;
      w_k   = r_k;
      w_upd = w_lane_en[gi];
      case (w_op)
        OP_NOP:  w_upd = 1'b0;
        OP_LOAD: begin w_r = w_n;          w_k = 1'b0;      end
        OP_ADD:  begin w_r = w_sum[3:0];   w_k = w_sum[4];  end
        OP_SUB:  begin w_r = w_diff[3:0];  w_k = w_diff[4]; end
        OP_AND:  begin w_r = r_q & w_n;    w_k = 1'b0;      end
        OP_OR:   begin w_r = r_q | w_n;    w_k = 1'b0;      end
        OP_XOR:  begin w_r = r_q ^ w_n;    w_k = 1'b0;      end
        OP_CLR:  begin w_r = 4'd0;         w_k = 1'b0;      end
        default: w_upd = 1'b0;
      endcase
    end

    // Lane accumulator and flag; async clear, load only when the lane updates.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= 4'd0;
        r_k <= 1'b0;
      end else if (w_upd) begin
        r_q <= w_r;
        r_k <= w_k;
      end
    end

    assign w_q[gi]     = r_q;
    assign w_carry[gi] = r_k;
  end

  assign QA    = w_q[0];
  assign QB    = w_q[1];
  assign QC    = w_q[2];
  assign QD    = w_q[3];
  assign carry = w_carry;
  // Zero flag looks at every lane regardless of vec.
  assign zero  = (w_q[0] == 4'd0) && (w_q[1] == 4'd0) &&
                 (w_q[2] == 4'd0) && (w_q[3] == 4'd0);

endmodule

// File: tb/tb_datapath.sv
// Scoreboarded bench for the four-lane SIMD datapath: the driver computes the
// expected lane state with a plain arithmetic model and queues it; a monitor
// compares when the corresponding clock edge has taken effect.
module tb_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] op = 3'd0;
  logic       form = 1'b0;
  logic [1:0] vec = 2'd0;
  logic [3:0] A = 4'd0, B = 4'd0, C = 4'd0, D = 4'd0;
  logic [3:0] QA, QB, QC, QD;
  logic [3:0] carry;
  logic       zero;

  datapath dut (
    .clk(clk), .rst(rst), .op(op), .form(form), .vec(vec),
    .A(A), .B(B), .C(C), .D(D),
    .QA(QA), .QB(QB), .QC(QC), .QD(QD),
    .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         id;
    logic [2:0] op;
    logic       form;
    logic [1:0] vec;
    logic [3:0] q [4];
    logic [3:0] k;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_txn   = 0;

  // Reference state: plain integers per lane.
  int m_q [4];
  int m_k [4];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_q[i] = 0;
      m_k[i] = 0;
    end
  endfunction

  function automatic void model_step(input int o, input int f, input int v,
                                     input int a, input int b, input int c, input int d);
    int in_v [4];
    int n, s;
    in_v[0] = a; in_v[1] = b; in_v[2] = c; in_v[3] = d;
    if (o == 0) return;
    for (int i = 0; i <= v; i++) begin
      n = (f != 0) ? a : in_v[i];
      case (o)
        1: begin m_q[i] = n; m_k[i] = 0; end
        2: begin s = m_q[i] + n; m_q[i] = s % 16; m_k[i] = (s >= 16) ? 1 : 0; end
        3: begin m_k[i] = (m_q[i] < n) ? 1 : 0; m_q[i] = (m_q[i] - n + 16) % 16; end
        4: begin m_q[i] = m_q[i] & n; m_k[i] = 0; end
        5: begin m_q[i] = m_q[i] | n; m_k[i] = 0; end
        6: begin m_q[i] = m_q[i] ^ n; m_k[i] = 0; end
        default: begin m_q[i] = 0; m_k[i] = 0; end
      endcase
    end
  endfunction

  // Apply one op for one clock and queue the state expected after that edge.
  task automatic issue(input int o, input int f, input int v,
                       input int a, input int b, input int c, input int d);
    exp_t e;
    @(negedge clk);
    op = 3'(o); form = 1'(f); vec = 2'(v);
    A = 4'(a); B = 4'(b); C = 4'(c); D = 4'(d);
    model_step(o, f, v, a, b, c, d);
    e.due = cyc + 1;
    e.id = n_txn++;
    e.op = 3'(o); e.form = 1'(f); e.vec = 2'(v);
    e.z = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.q[i] = 4'(m_q[i]);
      e.k[i] = 1'(m_k[i]);
      if (m_q[i] != 0) e.z = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Wait (bounded) until every queued expectation has been checked.
  task automatic drain();
    int budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    rst = 1'b1;
    op = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare every expectation whose edge has just taken effect.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("QA", 16'(QA), 16'(e.q[0]));
        chk("QB", 16'(QB), 16'(e.q[1]));
        chk("QC", 16'(QC), 16'(e.q[2]));
        chk("QD", 16'(QD), 16'(e.q[3]));
        chk("carry", 16'(carry), 16'(e.k));
        chk("zero", 16'(zero), 16'(e.z));
        $display("[TB] txn %0d op=%0d form=%0d vec=%0d -> Q=%h/%h/%h/%h carry=%b zero=%b",
                 e.id, e.op, e.form, e.vec, QA, QB, QC, QD, carry, zero);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    // Power-on reset with idle inputs.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_QA", 16'(QA), 16'h0);
    chk("rst_carry", 16'(carry), 16'h0);
    chk("rst_zero", 16'(zero), 16'h1);
    issue(0, 0, 0, 0, 0, 0, 0);

    // LOAD all lanes, then idle.
    issue(1, 0, 3, 1, 2, 3, 4);
    repeat (3) issue(0, 0, 3, 9, 9, 9, 9);
    // NOP must hold even with vec selecting no extra lanes.
    issue(0, 1, 0, 15, 15, 15, 15);
    drain();
    chk("load_Q", {QD, QC, QB, QA}, 16'h4321);
    chk("load_zero", 16'(zero), 16'h0);

    // ADD with wrap-around.
    issue(2, 0, 3, 15, 1, 0, 12);
    drain();
    chk("add_Q", {QD, QC, QB, QA}, 16'h0330);
    chk("add_carry", 16'(carry), 16'b1001);

    // Lane masking + broadcast SUB.
    do_reset();
    issue(1, 0, 3, 1, 2, 3, 4);
    issue(3, 1, 1, 2, 7, 7, 7);
    drain();
    chk("sub_Q", {QD, QC, QB, QA}, 16'h430F);
    chk("sub_carry", 16'(carry), 16'b0001);

    // Logic then clear.
    issue(1, 0, 3, 10, 5, 15, 0);
    issue(6, 1, 3, 15, 0, 0, 0);
    drain();
    chk("xor_Q", {QD, QC, QB, QA}, 16'hF0A5);
    issue(7, 0, 3, 0, 0, 0, 0);
    drain();
    chk("clr_Q", {QD, QC, QB, QA}, 16'h0000);
    chk("clr_zero", 16'(zero), 16'h1);
    chk("clr_carry", 16'(carry), 16'h0);

    // Asynchronous reset in the middle of an ADD sequence.
    issue(1, 0, 3, 1, 2, 3, 4);
    issue(2, 0, 3, 1, 1, 1, 1);
    drain();
    chk("pre_rst_zero", 16'(zero), 16'h0);
    op = 3'd2; form = 1'b0; vec = 2'd3; A = 4'd1; B = 4'd1; C = 4'd1; D = 4'd1;
    #2 rst = 1'b1;
    #1;
    chk("async_Q", {QD, QC, QB, QA}, 16'h0000);
    chk("async_carry", 16'(carry), 16'h0);
    chk("async_zero", 16'(zero), 16'h1);
    @(posedge clk);
    #1;
    chk("held_Q", {QD, QC, QB, QA}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    op = 3'd0;
    model_reset();
    issue(0, 0, 3, 0, 0, 0, 0);

    // Randomized traffic with occasional resets.
    for (int t = 0; t < 400; t++) begin
      if (t % 137 == 136) do_reset();
      issue($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
